// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the request record.
package mem_arb_pkg;

  // Widest address the request record can carry; ADDR_W must not exceed this.
  localparam int unsigned MaxAddrW = 64;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } arb_state_e;

  typedef struct packed {
    logic                instr;
    logic [MaxAddrW-1:0] addr;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotating-priority encoder: picks the first set request scanning upward from
// last_grant+1 (mod NUM_PORTS). Purely combinational.
module mem_arb_rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 any,
  output logic [IDX_W-1:0]     grant
);

  // Scan every port once, starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    logic        found;
    any   = |req;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = (32'(last_grant) + k) % NUM_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter funnelling NUM_PORTS core memory ports onto one
// downstream port. One transaction in flight; every dn_* / up_ready / up_rdata
// output comes straight from a flop.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        up_valid,
  input  logic [NUM_PORTS-1:0]        up_instr,
  input  logic [NUM_PORTS*ADDR_W-1:0] up_addr,
  input  logic [NUM_PORTS*32-1:0]     up_wdata,
  input  logic [NUM_PORTS*4-1:0]      up_wstrb,
  output logic [NUM_PORTS-1:0]        up_ready,
  output logic [31:0]                 up_rdata,
  output logic                        dn_valid,
  output logic                        dn_instr,
  output logic [ADDR_W-1:0]           dn_addr,
  output logic [31:0]                 dn_wdata,
  output logic [3:0]                  dn_wstrb,
  input  logic                        dn_ready,
  input  logic [31:0]                 dn_rdata,
  output logic                        busy
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e      state;
  logic [IdxW-1:0] last_grant;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  mem_req_t        sel_req;
  mem_req_t        req_q;

  mem_arb_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IdxW)
  ) u_rr_pick (
    .req       (up_valid),
    .last_grant(last_grant),
    .any       (pick_any),
    .grant     (pick_idx)
  );

  // Gather the winning port's request fields into one record.
  always_comb begin
    sel_req                  = '0;
    sel_req.instr            = up_instr[pick_idx];
    sel_req.addr[ADDR_W-1:0] = up_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_req.wdata            = up_wdata[int'(pick_idx)*32 +: 32];
    sel_req.wstrb            = up_wstrb[int'(pick_idx)*4 +: 4];
  end

  // Arbitration FSM; last_grant doubles as the index of the in-flight port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      dn_valid   <= 1'b0;
      up_ready   <= '0;
      up_rdata   <= '0;
      req_q      <= '0;
      last_grant <= IdxW'(NUM_PORTS - 1);
    end else begin
      case (state)
        StIdle: begin
          if (pick_any) begin
            req_q      <= sel_req;
            dn_valid   <= 1'b1;
            last_grant <= pick_idx;
            state      <= StBusy;
          end
        end
        StBusy: begin
          if (dn_ready) begin
            dn_valid <= 1'b0;
            up_rdata <= dn_rdata;
            up_ready <= NUM_PORTS'(1) << last_grant;
            state    <= StResp;
          end
        end
        StResp: begin
          up_ready <= '0;
          state    <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign dn_instr = req_q.instr;
  assign dn_addr  = req_q.addr[ADDR_W-1:0];
  assign dn_wdata = req_q.wdata;
  assign dn_wstrb = req_q.wstrb;

  // Upper record bits are constant zero for narrow addresses.
  if (ADDR_W < MaxAddrW) begin : g_addr_pad
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_q.addr[MaxAddrW-1:ADDR_W];
  end

  // Report activity as soon as any port asks, not only once granted.
  always_comb begin
    busy = (state != StIdle) || (|up_valid);
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arb;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    up_valid;
  logic [N-1:0]    up_instr;
  logic [N*AW-1:0] up_addr;
  logic [N*32-1:0] up_wdata;
  logic [N*4-1:0]  up_wstrb;
  logic [N-1:0]    up_ready;
  logic [31:0]     up_rdata;
  logic            dn_valid;
  logic            dn_instr;
  logic [AW-1:0]   dn_addr;
  logic [31:0]     dn_wdata;
  logic [3:0]      dn_wstrb;
  logic            dn_ready;
  logic [31:0]     dn_rdata;
  logic            busy;

  mem_arb #(
    .NUM_PORTS(N),
    .ADDR_W   (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_valid(up_valid),
    .up_instr(up_instr),
    .up_addr (up_addr),
    .up_wdata(up_wdata),
    .up_wstrb(up_wstrb),
    .up_ready(up_ready),
    .up_rdata(up_rdata),
    .dn_valid(dn_valid),
    .dn_instr(dn_instr),
    .dn_addr (dn_addr),
    .dn_wdata(dn_wdata),
    .dn_wstrb(dn_wstrb),
    .dn_ready(dn_ready),
    .dn_rdata(dn_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 60)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_last;   // port that won most recently
  bit          m_open;   // a request is out on the downstream side
  bit          m_resp;   // completion is being reported this cycle
  int          m_g;      // port owning the current transaction
  logic        e_valid, e_instr;
  logic [AW-1:0] e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic [3:0]  e_wstrb;
  logic [N-1:0] e_ready;

  task automatic model_reset();
    m_last  = N - 1;
    m_open  = 0;
    m_resp  = 0;
    m_g     = 0;
    e_valid = 0;
    e_instr = 0;
    e_addr  = '0;
    e_wdata = '0;
    e_wstrb = '0;
    e_rdata = '0;
    e_ready = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int p;
    if (m_resp) begin
      m_resp  = 0;
      e_ready = '0;
    end else if (m_open) begin
      if (dn_ready) begin
        m_open         = 0;
        m_resp         = 1;
        e_valid        = 0;
        e_rdata        = dn_rdata;
        e_ready        = '0;
        e_ready[m_g]   = 1'b1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        p = (m_last + k) % N;
        if (up_valid[p]) begin
          m_g     = p;
          m_last  = p;
          m_open  = 1;
          e_valid = 1;
          e_instr = up_instr[p];
          e_addr  = up_addr[p*AW +: AW];
          e_wdata = up_wdata[p*32 +: 32];
          e_wstrb = up_wstrb[p*4 +: 4];
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("dn_valid", 64'(dn_valid), 64'(e_valid));
    chk("dn_instr", 64'(dn_instr), 64'(e_instr));
    chk("dn_addr", 64'(dn_addr), 64'(e_addr));
    chk("dn_wdata", 64'(dn_wdata), 64'(e_wdata));
    chk("dn_wstrb", 64'(dn_wstrb), 64'(e_wstrb));
    chk("up_ready", 64'(up_ready), 64'(e_ready));
    chk("up_rdata", 64'(up_rdata), 64'(e_rdata));
    chk("busy", 64'(busy), 64'(m_open || m_resp || (|up_valid)));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // returns at the next falling edge ready for new stimulus.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    up_instr[p]          = instr;
    up_addr[p*AW +: AW]  = addr;
    up_wdata[p*32 +: 32] = wdata;
    up_wstrb[p*4 +: 4]   = wstrb;
  endtask

  task automatic drain();
    up_valid = '0;
    dn_ready = 1'b1;
    repeat (4) cycle();
    dn_ready = 1'b0;
  endtask

  logic [31:0] order_exp [5];
  logic [31:0] got_addr [$];
  int          pulses;
  logic        prev_valid;

  initial begin
    up_valid = '0;
    up_instr = '0;
    up_addr  = '0;
    up_wdata = '0;
    up_wstrb = '0;
    dn_ready = 1'b0;
    dn_rdata = '0;
    rst      = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state, literal values.
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_up_ready", 64'(up_ready), 64'd0);
    chk("rst_dn_addr", 64'(dn_addr), 64'd0);
    chk("rst_up_rdata", 64'(up_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single read on port 2.
    set_port(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    up_valid = 4'b0100;
    cycle();
    chk("rd_dn_valid", 64'(dn_valid), 64'd1);
    chk("rd_dn_addr", 64'(dn_addr), 64'h8000_0000);
    up_valid = '0;
    dn_ready = 1'b1;
    dn_rdata = 32'hDEAD_BEEF;
    cycle();
    chk("rd_up_ready", 64'(up_ready), 64'b0100);
    chk("rd_up_rdata", 64'(up_rdata), 64'hDEAD_BEEF);
    chk("rd_dn_valid_low", 64'(dn_valid), 64'd0);
    dn_ready = 1'b0;
    cycle();
    chk("rd_pulse_end", 64'(up_ready), 64'd0);

    // dn_ready high while idle with no requests.
    dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("idle_up_ready", 64'(up_ready), 64'd0);
      chk("idle_dn_valid", 64'(dn_valid), 64'd0);
    end
    dn_ready = 1'b0;

    // All ports requesting after reset: rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 1'b1, 32'h1000 * (i + 1), 32'h0, 4'h0);
    order_exp[0] = 32'h1000;
    order_exp[1] = 32'h2000;
    order_exp[2] = 32'h3000;
    order_exp[3] = 32'h4000;
    order_exp[4] = 32'h1000;
    up_valid   = '1;
    dn_ready   = 1'b1;
    prev_valid = 1'b0;
    got_addr.delete();
    for (int i = 0; i < 40 && got_addr.size() < 5; i++) begin
      cycle();
      if (dn_valid && !prev_valid) got_addr.push_back(dn_addr);
      prev_valid = dn_valid;
    end
    chk("rr_count", 64'(got_addr.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_addr.size(); i++)
      chk($sformatf("rr_order[%0d]", i), 64'(got_addr[i]), 64'(order_exp[i]));
    drain();

    // Port 1 write with dn_ready delayed: fields stable over 6 busy cycles.
    set_port(1, 1'b0, 32'h2000_0040, 32'h1234_5678, 4'hF);
    up_valid = 4'b0010;
    cycle();
    up_valid = '0;
    pulses   = 0;
    for (int k = 0; k < 6; k++) begin
      chk("wr_dn_valid", 64'(dn_valid), 64'd1);
      chk("wr_dn_addr", 64'(dn_addr), 64'h2000_0040);
      chk("wr_dn_wdata", 64'(dn_wdata), 64'h1234_5678);
      chk("wr_dn_wstrb", 64'(dn_wstrb), 64'hF);
      if (k == 5) begin
        dn_ready = 1'b1;
        dn_rdata = 32'h0BAD_F00D;
      end
      cycle();
      pulses += int'(up_ready[1]);
    end
    dn_ready = 1'b0;
    repeat (3) begin
      cycle();
      pulses += int'(up_ready[1]);
    end
    chk("wr_pulses", 64'(pulses), 64'd1);

    // Reset during a transaction.
    set_port(2, 1'b0, 32'h3000_0000, 32'h0, 4'h0);
    up_valid = 4'b0100;
    cycle();
    up_valid = '0;
    cycle();
    chk("rb_in_busy", 64'(dn_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rb_dn_valid_now", 64'(dn_valid), 64'd0);
    chk("rb_up_ready_now", 64'(up_ready), 64'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_port(i, 1'b0, 32'hA000 + 32'(i), 32'h0, 4'h0);
    up_valid = '1;
    cycle();
    chk("rb_first_grant", 64'(dn_addr), 64'hA000);
    drain();

    // Port 3 drops its request while granted; completion still pulses.
    set_port(3, 1'b1, 32'h4000_0100, 32'h0, 4'h0);
    up_valid = 4'b1000;
    cycle();
    up_valid = '0;
    pulses   = 0;
    cycle();
    cycle();
    dn_ready = 1'b1;
    cycle();
    pulses += int'(up_ready[3]);
    chk("drop_ready", 64'(up_ready), 64'b1000);
    dn_ready = 1'b0;
    repeat (3) begin
      cycle();
      pulses += int'(up_ready[3]);
    end
    chk("drop_pulses", 64'(pulses), 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        up_valid = N'($urandom & $urandom);
        for (int i = 0; i < N; i++)
          set_port(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
        dn_ready = 1'($urandom);
        dn_rdata = $urandom;
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
